uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised second-generation UART transmitter with configurable data width, runtime parity and stop-bit selection, and a TX queue. It accepts words via a valid/ready handshake, queues them, and serialises each as an idle-high, LSB-first frame: start, data, optional parity, stop(s). It sits in the same place as the first-generation transmitter: host/CPU-side logic writes words, and DOUT drives the board TX pin.

## Interface
- CLK_FREQ, 125_000_000, input clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s; DIV = round(CLK_FREQ/BAUD_RATE) clocks per bit, DIV ≥ 2
- DATA_BITS, 8, data bits per frame, legal 5..9
- FIFO_DEPTH, 16, queue depth in words, power of two ≥ 2 (used only with UART_TX_FIFO_EN)
- CLK  input  1  single clock; all logic on its rising edge
- RST  input  1  reset; synchronous and active-high
- SEND  input  1  word valid
- DIN  input  DATA_BITS  word to transmit
- READY  output  1  queue can accept; transfer occurs on an edge where SEND && READY
- PARITY_MODE  input  2  00 none, 01 even, 10 odd, 11 treated as none
- STOP_BITS  input  1  0 = one stop bit, 1 = two stop bits
- BUSY  output  1  high while a frame is in progress or the queue is non-empty
- DOUT  output  1  serial line, registered
- FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  words queued and not yet started

## Operation
- Reset values: DOUT=1, BUSY=0, READY=1, FIFO_LEVEL=0; FSM in IDLE; queue and baud counter cleared.
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE or START.
  - IDLE: when the queue is non-empty, pop the head into the shift register and go to START. PARITY_MODE and STOP_BITS are latched on this same edge and held for the whole frame.
  - START: DOUT=0 for DIV clocks.
  - DATA: DOUT = shift[0] for DIV clocks per bit; shift right; DATA_BITS bits; a bit counter counts 0..DATA_BITS-1.
  - PARITY: entered only if the latched mode is even or odd. The bit is the XOR of the data bits (even), or its inverse (odd). Parity is computed from the popped word at load time.
  - STOP: DOUT=1 for DIV clocks (one stop bit) or 2·DIV clocks (two).
  - End of STOP: if the queue is non-empty, pop and go directly to START (zero idle clocks between frames); otherwise go to IDLE.
- Baud counter: runs 0..DIV-1 and is cleared on every frame start, not free-running. Every bit is exactly DIV clocks.
- BUSY = (state ≠ IDLE) || (FIFO_LEVEL ≠ 0).
- SEND while READY=0: ignored; the word is not captured and the sender must hold it.
- Push and pop on the same edge: FIFO_LEVEL is unchanged.
- Changing PARITY_MODE or STOP_BITS mid-frame: no effect until the next frame start.
- RST mid-frame: on the next edge DOUT=1, the frame is aborted, and the queue is flushed. There is no partial stop bit.

## Timing
- Latency: a word accepted at edge N with the queue empty and FSM in IDLE is popped at edge N+1. DOUT is low from edge N+1.
- Frame length in clocks: DIV·(1 + DATA_BITS + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- READY is combinational from the registered queue level; it has no dependence on SEND.

## Configuration
- UART_TX_FIFO_EN defined:
  - The queue is a FIFO_DEPTH-entry circular buffer with wrap-around pointers.
  - READY = (FIFO_LEVEL < FIFO_DEPTH).
- UART_TX_FIFO_EN undefined:
  - The queue is a single holding register; FIFO_DEPTH is ignored.
  - READY = !full, and FIFO_LEVEL is 0 or 1.
  - One word can be staged while a frame is sent. READY reasserts the edge after the holding word is moved to the shift register.

## Structure
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - PARITY_MODE encodings (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the function computing DIV from CLK_FREQ and BAUD_RATE.
- One sub-module, uart_tx_queue, contains both the circular FIFO and the holding-register variant, selected by UART_TX_FIFO_EN. The FSM, baud counter and shift register remain in uart_tx_param.

## Test plan
All scenarios use CLK_FREQ=1000 and BAUD_RATE=100, so DIV=10.
- DIN=0x55, even parity, 1 stop → DOUT sequence 0,1,0,1,0,1,0,1,0,0,1, each bit 10 clocks, 110 clocks total; BUSY falls the edge after the stop bit ends.
- DIN=0x00, odd parity, 2 stop → parity bit 1, stop high for 20 clocks, frame 120 clocks.
- DATA_BITS=7, PARITY_MODE=11, STOP_BITS=1, DIN=0x7F → 9-bit frame with no parity bit, 90 clocks.
- With UART_TX_FIFO_EN, FIFO_DEPTH=16, hold SEND high with incrementing DIN → 17 words accepted (first popped immediately); then READY=0 with FIFO_LEVEL=16; frames back-to-back with no idle clocks; READY reasserts after each frame's pop.
- Without UART_TX_FIFO_EN, issue three SEND pulses in consecutive clocks → words 1 and 2 accepted; word 3 is stalled (READY=0) until word 2 starts its START bit.
- Assert RST during DATA bit 3 → DOUT=1, BUSY=0, FIFO_LEVEL=0, READY=1 on the next edge; a following SEND transmits a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return (clk_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side word interface of uart_tx_param: handshake, frame config and line/status outputs.
interface uart_tx_param_if #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic                 SEND;
    logic [DATA_BITS-1:0] DIN;
    logic                 READY;
    logic [1:0]           PARITY_MODE;
    logic                 STOP_BITS;
    logic                 BUSY;
    logic                 DOUT;
    logic [LW-1:0]        FIFO_LEVEL;

    modport master (
        output SEND, DIN, PARITY_MODE, STOP_BITS,
        input  READY, BUSY, DOUT, FIFO_LEVEL
    );

    modport slave (
        input  SEND, DIN, PARITY_MODE, STOP_BITS,
        output READY, BUSY, DOUT, FIFO_LEVEL
    );

endinterface

// File: rtl/uart_tx_queue.sv
// TX word queue: circular FIFO when UART_TX_FIFO_EN is defined, otherwise a single holding register.
module uart_tx_queue #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] rdata_o,
    output logic [LW-1:0]        level_o,
    output logic                 ready_o
);

`ifdef UART_TX_FIFO_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 do_push, do_pop;

    always_comb begin
        do_push  = push_i && (level_q < DEPTH_L);
        do_pop   = pop_i && (level_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign ready_o = (level_q < DEPTH_L);
`else
    logic                 full_q, full_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i && full_q) begin
            full_d = 1'b0;
        end
        if (push_i && !full_q) begin
            full_d = 1'b1;
            data_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign rdata_o = data_q;
    assign level_o = {{(LW - 1){1'b0}}, full_q};
    assign ready_o = !full_q;
`endif

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: queue, baud counter, shift register and frame FSM.
// Queue depth behaviour is selected by the UART_TX_FIFO_EN macro (see uart_tx_queue).
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 125_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input logic            CLK,
    input logic            RST,
    uart_tx_param_if.slave bus
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned BW  = $clog2(DATA_BITS);
    localparam int unsigned LW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 par_en_q, par_en_d;
    logic                 stop2_q, stop2_d;
    logic                 dout_q, dout_d;

    logic                 pop, load, bit_end;
    logic [DATA_BITS-1:0] head;
    logic [LW-1:0]        level;
    logic                 q_ready;

    uart_tx_queue #(
        .DATA_BITS (DATA_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_queue (
        .clk_i  (CLK),
        .rst_i  (RST),
        .push_i (bus.SEND),
        .wdata_i(bus.DIN),
        .pop_i  (pop),
        .rdata_o(head),
        .level_o(level),
        .ready_o(q_ready)
    );

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        par_en_d = par_en_q;
        stop2_d  = stop2_q;
        dout_d   = dout_q;
        load     = 1'b0;
        bit_end  = (cnt_q == CNT_LAST);
        cnt_d    = bit_end ? '0 : cnt_q + CW'(1);

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                load  = (level != '0);
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    dout_d  = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                        dout_d  = par_en_q ? par_q : 1'b1;
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shift_d = shift_q >> 1;
                        dout_d  = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    dout_d  = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // bit_q marks the first of two stop bits as done.
                    if (stop2_q && (bit_q == '0)) begin
                        bit_d = BW'(1);
                    end else if (level != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame start: pop, latch line config and precompute parity from the whole word.
        if (load) begin
            state_d  = START;
            cnt_d    = '0;
            dout_d   = 1'b0;
            shift_d  = head;
            par_d    = (^head) ^ (bus.PARITY_MODE == PAR_ODD);
            par_en_d = (bus.PARITY_MODE == PAR_EVEN) || (bus.PARITY_MODE == PAR_ODD);
            stop2_d  = bus.STOP_BITS;
        end
        pop = load;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            dout_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            stop2_q  <= stop2_d;
            dout_q   <= dout_d;
        end
    end

    assign bus.DOUT       = dout_q;
    assign bus.BUSY       = (state_q != IDLE) || (level != '0);
    assign bus.READY      = q_ready;
    assign bus.FIFO_LEVEL = level;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: expected frames queued on accept, checked as DOUT emits them.
module tb_uart_tx_param;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIVT     = 10;
    localparam int FD       = 16;

    typedef struct {
        logic [12:0] bits;
        int          n;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic [1:0] cur_pm = 2'b00;
    logic cur_s2 = 1'b0;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    frame_t exp_q[$];
    logic mon_dout;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(FD)) bus_a ();
    uart_tx_param_if #(.DATA_BITS(7), .FIFO_DEPTH(FD)) bus_b ();

    uart_tx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(8), .FIFO_DEPTH(FD)
    ) dut_a (
        .CLK(clk), .RST(rst), .bus(bus_a)
    );

    uart_tx_param #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_BITS(7), .FIFO_DEPTH(FD)
    ) dut_b (
        .CLK(clk), .RST(rst), .bus(bus_b)
    );

    assign mon_dout = sel ? bus_b.DOUT : bus_a.DOUT;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic frame_t make_frame(input logic [8:0] d, input int nb,
                                          input logic [1:0] pm, input logic s2);
        frame_t f;
        logic p;
        int k;
        f.bits = '0;
        p = 1'b0;
        k = 1;
        for (int i = 0; i < nb; i++) begin
            f.bits[k] = d[i];
            p ^= d[i];
            k++;
        end
        if (pm == 2'b01) begin
            f.bits[k] = p;
            k++;
        end else if (pm == 2'b10) begin
            f.bits[k] = ~p;
            k++;
        end
        f.bits[k] = 1'b1;
        k++;
        if (s2) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.n = k;
        return f;
    endfunction

    task automatic set_mode(input logic [1:0] pm, input logic s2);
        cur_pm = pm;
        cur_s2 = s2;
        bus_a.PARITY_MODE = pm;
        bus_a.STOP_BITS   = s2;
        bus_b.PARITY_MODE = pm;
        bus_b.STOP_BITS   = s2;
    endtask

    // Holds SEND until accepted; acc is the cycle number of the accepting edge.
    task automatic drive(input logic [8:0] d, output int acc);
        int w;
        logic rdy;
        w = 0;
        acc = -1;
        if (sel) begin
            bus_b.SEND = 1'b1;
            bus_b.DIN  = d[6:0];
        end else begin
            bus_a.SEND = 1'b1;
            bus_a.DIN  = d[7:0];
        end
        while (acc < 0) begin
            @(negedge clk);
            rdy = sel ? bus_b.READY : bus_a.READY;
            if (rdy === 1'b1) begin
                exp_q.push_back(make_frame(d, sel ? 7 : 8, cur_pm, cur_s2));
                @(posedge clk);
                #1;
                acc = cyc;
            end else begin
                w++;
                if (w > 400) begin
                    check_eq("send_timeout", w, 0);
                    acc = cyc;
                end
            end
        end
        bus_a.SEND = 1'b0;
        bus_b.SEND = 1'b0;
    endtask

    task automatic wait_idle(output int t);
        int w;
        logic bsy;
        w = 0;
        t = -1;
        while (t < 0) begin
            @(posedge clk);
            #1;
            bsy = sel ? bus_b.BUSY : bus_a.BUSY;
            if (bsy === 1'b0) begin
                t = cyc;
            end else begin
                w++;
                if (w > 3000) begin
                    check_eq("idle_timeout", w, 0);
                    t = cyc;
                end
            end
        end
    endtask

    // Monitor: samples first and last clock of every bit so bit width is checked too.
    initial begin
        frame_t f;
        logic [12:0] first, last;
        logic aborted;
        forever begin
            @(negedge clk);
            if (!rst && mon_dout === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_frame", exp_q.size(), 1);
                    while (mon_dout === 1'b0) @(negedge clk);
                end else begin
                    f = exp_q.pop_front();
                    first = '0;
                    last = '0;
                    aborted = 1'b0;
                    for (int c = 0; c < f.n * DIVT; c++) begin
                        if (c > 0) @(negedge clk);
                        if (rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c % DIVT == 0) first[c / DIVT] = mon_dout;
                        if (c % DIVT == DIVT - 1) last[c / DIVT] = mon_dout;
                    end
                    if (!aborted) begin
                        check_eq("frame_bits_first", first, f.bits);
                        check_eq("frame_bits_last", last, f.bits);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, t;
        int acc [18];
        bus_a.SEND = 1'b0;
        bus_a.DIN  = '0;
        bus_b.SEND = 1'b0;
        bus_b.DIN  = '0;
        set_mode(2'b00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_eq("rst_dout_a", bus_a.DOUT, 1);
        check_eq("rst_busy_a", bus_a.BUSY, 0);
        check_eq("rst_ready_a", bus_a.READY, 1);
        check_eq("rst_level_a", bus_a.FIFO_LEVEL, 0);
        check_eq("rst_dout_b", bus_b.DOUT, 1);

        // 0x55 even, 1 stop; config change mid-frame must not affect it.
        set_mode(2'b01, 1'b0);
        drive(9'h055, a0);
        repeat (20) @(posedge clk);
        #1;
        bus_a.PARITY_MODE = 2'b00;
        bus_a.STOP_BITS   = 1'b1;
        wait_idle(t);
        check_eq("len_55_even_1stop", t - a0, 1 + 110);

        set_mode(2'b10, 1'b1);
        drive(9'h000, a0);
        wait_idle(t);
        check_eq("len_00_odd_2stop", t - a0, 1 + 120);

        sel = 1'b1;
        set_mode(2'b11, 1'b0);
        drive(9'h07f, a0);
        wait_idle(t);
        check_eq("len_7bit_mode11", t - a0, 1 + 90);
        sel = 1'b0;

        // Three words offered back to back.
        set_mode(2'b00, 1'b0);
        drive(9'h001, a0);
        drive(9'h002, a1);
        check_eq("w2_level", bus_a.FIFO_LEVEL, 1);
`ifdef UART_TX_FIFO_EN
        check_eq("w2_ready", bus_a.READY, 1);
        drive(9'h003, a2);
        check_eq("w2_accept_delay", a1 - a0, 1);
        check_eq("w3_accept_delay", a2 - a0, 2);
`else
        check_eq("w2_ready", bus_a.READY, 0);
        drive(9'h003, a2);
        check_eq("w2_accept_delay", a1 - a0, 2);
        check_eq("w3_accept_delay", a2 - a0, 2 + 100);
`endif
        wait_idle(t);
        check_eq("len_three_frames", t - a0, 1 + 300);

`ifdef UART_TX_FIFO_EN
        // Fill the FIFO with SEND held high.
        for (int i = 0; i < 17; i++) drive(9'(8'h10 + i), acc[i]);
        check_eq("fill_accept_span", acc[16] - acc[0], 16);
        check_eq("fill_level", bus_a.FIFO_LEVEL, 16);
        check_eq("fill_ready", bus_a.READY, 0);
        drive(9'h0ee, acc[17]);
        check_eq("fill_reaccept", acc[17] - acc[0], 2 + 100);
        wait_idle(t);
        check_eq("len_18_frames", t - acc[0], 1 + 1800);
`endif

        // Reset during data bit 3 with a second word staged.
        drive(9'h0a5, a0);
        drive(9'h03c, a1);
        while (cyc < a0 + 44) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_rst_level", bus_a.FIFO_LEVEL, 1);
        check_eq("pre_rst_bit3", bus_a.DOUT, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_dout", bus_a.DOUT, 1);
        check_eq("rst_mid_busy", bus_a.BUSY, 0);
        check_eq("rst_mid_level", bus_a.FIFO_LEVEL, 0);
        check_eq("rst_mid_ready", bus_a.READY, 1);
        exp_q.delete();
        rst = 1'b0;
        drive(9'h096, a0);
        wait_idle(t);
        check_eq("len_after_rst", t - a0, 1 + 100);

        repeat (5) @(posedge clk);
        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
